dcache_port_arbiter: RTL and testbench

//  Shares the single data-cache port between the load pipe and the store-data-queue drain.

---
 rtl/dcache_port_arbiter_pkg.sv | 21 ++
 rtl/dcache_port_arbiter_starve_ctr.sv | 41 ++++
 rtl/dcache_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and defaults for the data-cache port arbiter.
//   arb_state_e   : port FSM states (idle -> request -> wait for response)
//   starve_cnt_w  : width needed for a saturating counter that reaches a given limit
package dcache_port_arbiter_pkg;

  localparam int unsigned DefAddrW       = 32;
  localparam int unsigned DefDataW       = 32;
  localparam int unsigned DefTagW        = 6;
  localparam int unsigned DefStarveLimit = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } arb_state_e;

  function automatic int unsigned starve_cnt_w(int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_starve_ctr.sv
// Saturating starvation counter for the pending store.
//   clk, rst     : clock, synchronous active-high reset
//   inc_i        : store pending and not granted this cycle
//   clr_i        : store granted or no store pending (wins over inc_i)
//   at_limit_o   : counter has reached LIMIT
module dcache_port_arbiter_starve_ctr
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = DefStarveLimit
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = starve_cnt_w(LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == CntW'(LIMIT));

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache port between the load pipe and the SDQ store drain.
// Loads win by default; a pending store wins when the SDQ is full, when it has starved for
// STARVE_LIMIT cycles, or when no port load competes. Loads that hit in the SDQ complete
// from forwarded data without touching the port. One cache request is outstanding at a time.
//   clk, rst                 : clock, synchronous active-high reset
//   flush_i                  : kills pending / in-flight loads (stores are unaffected)
//   ld_req_*_i / ld_req_rdy_o: load request, SDQ forward hit/data, acceptance
//   ld_resp_*_o              : load completion (forwarded or from the cache)
//   st_req_*_i / st_req_rdy_o: SDQ head store, acceptance pops the head
//   sdq_full_i               : SDQ full, forces store priority
//   mem_req_*_o / mem_req_rdy_i : cache request channel (valid/ready)
//   mem_resp_*_i             : cache response (load data or store ack)
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned TAG_W        = DefTagW,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ld_req_vld_i,
  input  logic [ADDR_W-1:0] ld_req_addr_i,
  input  logic [TAG_W-1:0]  ld_req_tag_i,
  input  logic              ld_fwd_hit_i,
  input  logic [DATA_W-1:0] ld_fwd_data_i,
  output logic              ld_req_rdy_o,
  output logic              ld_resp_vld_o,
  output logic [DATA_W-1:0] ld_resp_data_o,
  output logic [TAG_W-1:0]  ld_resp_tag_o,
  input  logic              st_req_vld_i,
  input  logic [ADDR_W-1:0] st_req_addr_i,
  input  logic [DATA_W-1:0] st_req_data_i,
  input  logic              sdq_full_i,
  output logic              st_req_rdy_o,
  output logic              mem_req_vld_o,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  input  logic              mem_req_rdy_i,
  input  logic              mem_resp_vld_i,
  input  logic [DATA_W-1:0] mem_resp_data_i
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  arb_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic        killed_q, killed_d;

  logic              resp_vld_q, resp_vld_d;
  logic              resp_fwd_q, resp_fwd_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;

  logic in_idle, port_ld, st_win, ld_win, port_ld_resp, fwd_acc;
  logic starve_at_limit, starve_inc, starve_clr;

  // Arbitration and acceptance
  always_comb begin
    in_idle      = (state_q == StIdle);
    port_ld      = ld_req_vld_i & ~ld_fwd_hit_i & ~flush_i;
    st_win       = in_idle & st_req_vld_i & (sdq_full_i | starve_at_limit | ~port_ld);
    ld_win       = in_idle & port_ld & ~st_win;
    port_ld_resp = (state_q == StWait) & mem_resp_vld_i & ~req_q.we;
    // Blocking forwards during a port-load response keeps ld_resp to one per cycle.
    fwd_acc      = ld_req_vld_i & ld_fwd_hit_i & ~flush_i & ~port_ld_resp;
    st_req_rdy_o = ~rst & st_win;
    ld_req_rdy_o = ~rst & (ld_win | fwd_acc);
  end

  assign starve_inc = st_req_vld_i & ~st_req_rdy_o;
  assign starve_clr = st_req_rdy_o | ~st_req_vld_i;

  dcache_port_arbiter_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (starve_inc),
    .clr_i     (starve_clr),
    .at_limit_o(starve_at_limit)
  );

  // Port FSM next state
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    tag_d    = tag_q;
    killed_d = killed_q;
    unique case (state_q)
      StIdle: begin
        if (st_win) begin
          state_d  = StReq;
          req_d    = '{we: 1'b1, addr: st_req_addr_i, wdata: st_req_data_i};
          killed_d = 1'b0;
        end else if (ld_win) begin
          state_d  = StReq;
          req_d    = '{we: 1'b0, addr: ld_req_addr_i, wdata: '0};
          tag_d    = ld_req_tag_i;
          killed_d = 1'b0;
        end
      end
      StReq: begin
        // A killed load still finishes its handshake; only its response is discarded.
        if (flush_i && !req_q.we) killed_d = 1'b1;
        if (mem_req_rdy_i) state_d = StWait;
      end
      StWait: begin
        if (flush_i && !req_q.we) killed_d = 1'b1;
        if (mem_resp_vld_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Load response next state
  always_comb begin
    resp_vld_d  = 1'b0;
    resp_fwd_d  = 1'b0;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;
    if (fwd_acc) begin
      resp_vld_d  = 1'b1;
      resp_fwd_d  = 1'b1;
      resp_data_d = ld_fwd_data_i;
      resp_tag_d  = ld_req_tag_i;
    end else if (port_ld_resp && !killed_q && !flush_i) begin
      resp_vld_d  = 1'b1;
      resp_data_d = mem_resp_data_i;
      resp_tag_d  = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_q       <= '0;
      tag_q       <= '0;
      killed_q    <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_fwd_q  <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      tag_q       <= tag_d;
      killed_q    <= killed_d;
      resp_vld_q  <= resp_vld_d;
      resp_fwd_q  <= resp_fwd_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

  // A forwarded response waiting to be presented is dropped by a flush in that cycle.
  assign ld_resp_vld_o   = resp_vld_q & ~(resp_fwd_q & flush_i);
  assign ld_resp_data_o  = resp_data_q;
  assign ld_resp_tag_o   = resp_tag_q;
  assign mem_req_vld_o   = (state_q == StReq);
  assign mem_req_we_o    = req_q.we;
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_wdata_o = req_q.wdata;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ld_req_vld = 1'b0;
  logic [31:0] ld_req_addr = '0;
  logic [5:0]  ld_req_tag = '0;
  logic        ld_fwd_hit = 1'b0;
  logic [31:0] ld_fwd_data = '0;
  logic        ld_req_rdy, ld_resp_vld;
  logic [31:0] ld_resp_data;
  logic [5:0]  ld_resp_tag;
  logic        st_req_vld = 1'b0;
  logic [31:0] st_req_addr = '0, st_req_data = '0;
  logic        sdq_full = 1'b0;
  logic        st_req_rdy, mem_req_vld, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_req_rdy = 1'b0, mem_resp_vld = 1'b0;
  logic [31:0] mem_resp_data = '0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TAG_W(6), .STARVE_LIMIT(LIM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .ld_req_vld_i   (ld_req_vld),
    .ld_req_addr_i  (ld_req_addr),
    .ld_req_tag_i   (ld_req_tag),
    .ld_fwd_hit_i   (ld_fwd_hit),
    .ld_fwd_data_i  (ld_fwd_data),
    .ld_req_rdy_o   (ld_req_rdy),
    .ld_resp_vld_o  (ld_resp_vld),
    .ld_resp_data_o (ld_resp_data),
    .ld_resp_tag_o  (ld_resp_tag),
    .st_req_vld_i   (st_req_vld),
    .st_req_addr_i  (st_req_addr),
    .st_req_data_i  (st_req_data),
    .sdq_full_i     (sdq_full),
    .st_req_rdy_o   (st_req_rdy),
    .mem_req_vld_o  (mem_req_vld),
    .mem_req_we_o   (mem_req_we),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_wdata_o(mem_req_wdata),
    .mem_req_rdy_i  (mem_req_rdy),
    .mem_resp_vld_i (mem_resp_vld),
    .mem_resp_data_i(mem_resp_data)
  );

  typedef struct packed {
    logic        rst, flush, ld_vld;
    logic [31:0] ld_addr;
    logic [5:0]  ld_tag;
    logic        ld_hit;
    logic [31:0] ld_fwd;
    logic        st_vld;
    logic [31:0] st_addr, st_data;
    logic        full, mem_rdy, mem_resp;
    logic [31:0] mem_data;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr, wdata;
  } mreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    int unsigned cyc;
  } resp_t;

  mreq_t mem_q[$];
  resp_t resp_q[$];

  int passed = 0;
  int total = 0;
  int unsigned cyc = 0;
  int cyc_ph = 0;
  bit mon_on = 0;
  bit mem_clr = 0;

  // Reference model: port phase 0 = free, 1 = request offered, 2 = awaiting response.
  int ph = 0;
  int starve = 0;
  bit cur_ld = 0, cur_killed = 0;
  logic [5:0] cur_tag = '0;
  bit nx_vld = 0, nx_fwd = 0;
  logic [31:0] nx_data = '0;
  logic [5:0] nx_tag = '0;
  bit last_st_g = 0;

  // Random-mode SDQ head
  bit st_have = 0;
  logic [31:0] st_a = '0, st_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name, input string msg);
    total++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  task automatic step(input stim_t s);
    bit port_ld, st_g, ld_g, resp_now, fwd_acc;
    @(posedge clk);
    #1;
    if (mem_clr) begin
      mem_q.delete();
      mem_clr = 0;
    end
    cyc++;
    cyc_ph = ph;
    rst = s.rst; flush = s.flush;
    ld_req_vld = s.ld_vld; ld_req_addr = s.ld_addr; ld_req_tag = s.ld_tag;
    ld_fwd_hit = s.ld_hit; ld_fwd_data = s.ld_fwd;
    st_req_vld = s.st_vld; st_req_addr = s.st_addr; st_req_data = s.st_data;
    sdq_full = s.full; mem_req_rdy = s.mem_rdy; mem_resp_vld = s.mem_resp;
    mem_resp_data = s.mem_data;
    if (nx_vld && !(nx_fwd && s.flush))
      resp_q.push_back(resp_t'{data: nx_data, tag: nx_tag, cyc: cyc});
    nx_vld = 0;
    last_st_g = 0;
    #1;
    if (s.rst) begin
      chk("st_req_rdy_in_rst", 64'(st_req_rdy), 64'(0));
      chk("ld_req_rdy_in_rst", 64'(ld_req_rdy), 64'(0));
      ph = 0;
      starve = 0;
      mem_clr = 1;
      return;
    end
    port_ld  = s.ld_vld && !s.ld_hit && !s.flush;
    st_g     = (ph == 0) && s.st_vld && (s.full || starve == LIM || !port_ld);
    ld_g     = (ph == 0) && port_ld && !st_g;
    resp_now = (ph == 2) && s.mem_resp;
    fwd_acc  = s.ld_vld && s.ld_hit && !s.flush && !(resp_now && cur_ld);
    chk("st_req_rdy", 64'(st_req_rdy), 64'(st_g));
    chk("ld_req_rdy", 64'(ld_req_rdy), 64'(ld_g || fwd_acc));
    if (fwd_acc) begin
      nx_vld = 1; nx_fwd = 1; nx_data = s.ld_fwd; nx_tag = s.ld_tag;
    end else if (resp_now && cur_ld && !cur_killed && !s.flush) begin
      nx_vld = 1; nx_fwd = 0; nx_data = s.mem_data; nx_tag = cur_tag;
    end
    starve = (s.st_vld && !st_g) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
    if (ph != 0 && s.flush && cur_ld) cur_killed = 1;
    if (ph == 1 && s.mem_rdy) ph = 2;
    else if (resp_now) ph = 0;
    if (st_g) begin
      ph = 1; cur_ld = 0; last_st_g = 1;
      mem_q.push_back(mreq_t'{we: 1'b1, addr: s.st_addr, wdata: s.st_data});
    end else if (ld_g) begin
      ph = 1; cur_ld = 1; cur_killed = 0; cur_tag = s.ld_tag;
      mem_q.push_back(mreq_t'{we: 1'b0, addr: s.ld_addr, wdata: 32'h0});
    end
  endtask

  // Monitor: pops expected requests/responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mem_req_vld", 64'(mem_req_vld), 64'(cyc_ph == 1));
      if (mem_req_vld) begin
        if (mem_q.size() == 0) begin
          note_fail("mem_req_unexpected", $sformatf("addr %0h offered, none required", mem_req_addr));
        end else begin
          chk("mem_req_we", 64'(mem_req_we), 64'(mem_q[0].we));
          chk("mem_req_addr", 64'(mem_req_addr), 64'(mem_q[0].addr));
          chk("mem_req_wdata", 64'(mem_req_wdata), 64'(mem_q[0].wdata));
          if (mem_req_rdy) void'(mem_q.pop_front());
        end
      end
      if (ld_resp_vld) begin
        if (resp_q.size() == 0) begin
          note_fail("ld_resp_unexpected", $sformatf("tag %0h data %0h, none required",
                                                    ld_resp_tag, ld_resp_data));
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("ld_resp_data", 64'(ld_resp_data), 64'(e.data));
          chk("ld_resp_tag", 64'(ld_resp_tag), 64'(e.tag));
          chk("ld_resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
        note_fail("ld_resp_missing", $sformatf("expected tag %0h did not arrive", resp_q[0].tag));
        void'(resp_q.pop_front());
      end
    end
  end

  task automatic drain();
    stim_t s;
    for (int i = 0; i < 8; i++) begin
      s = '0;
      s.mem_rdy = 1'b1;
      s.mem_resp = (ph == 2);
      s.mem_data = $urandom;
      step(s);
    end
  endtask

  task automatic check_zero();
    chk("zero_mem_req_vld", 64'(mem_req_vld), 64'(0));
    chk("zero_mem_req_we", 64'(mem_req_we), 64'(0));
    chk("zero_mem_req_addr", 64'(mem_req_addr), 64'(0));
    chk("zero_mem_req_wdata", 64'(mem_req_wdata), 64'(0));
    chk("zero_ld_req_rdy", 64'(ld_req_rdy), 64'(0));
    chk("zero_st_req_rdy", 64'(st_req_rdy), 64'(0));
    chk("zero_ld_resp_vld", 64'(ld_resp_vld), 64'(0));
    chk("zero_ld_resp_data", 64'(ld_resp_data), 64'(0));
    chk("zero_ld_resp_tag", 64'(ld_resp_tag), 64'(0));
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s = '0;
    s.rst = ($urandom_range(0, 249) == 0);
    s.flush = !s.rst && ($urandom_range(0, 19) == 0);
    s.ld_vld = ($urandom_range(0, 1) == 1);
    s.ld_addr = $urandom;
    s.ld_tag = 6'($urandom);
    s.ld_hit = ($urandom_range(0, 3) == 0);
    s.ld_fwd = $urandom;
    if (!st_have && $urandom_range(0, 2) == 0) begin
      st_have = 1; st_a = $urandom; st_d = $urandom;
    end
    s.st_vld = st_have;
    s.st_addr = st_a;
    s.st_data = st_d;
    s.full = ($urandom_range(0, 7) == 0);
    s.mem_rdy = !s.rst && ($urandom_range(0, 1) == 1);
    s.mem_resp = (ph == 2) ? ($urandom_range(0, 2) == 0) : ((ph == 0) && $urandom_range(0, 15) == 0);
    s.mem_data = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s;
    int gnt_i, gnts;
    bit st_done;

    s = '0; s.rst = 1'b1;
    step(s);
    step(s);
    s = '0;
    step(s);
    check_zero();
    mon_on = 1;

    // Port load: addr 0x100 tag 5, cache returns 0xDEAD two cycles after accepting.
    s = '0; s.ld_vld = 1; s.ld_addr = 32'h100; s.ld_tag = 6'd5; step(s);
    s = '0; s.mem_rdy = 1; step(s);
    s = '0; step(s);
    s = '0; s.mem_resp = 1; s.mem_data = 32'hDEAD; step(s);
    drain();

    // Forwarded load while a store waits for its ack.
    s = '0; s.st_vld = 1; s.st_addr = 32'h200; s.st_data = 32'h55; step(s);
    s = '0; s.mem_rdy = 1; step(s);
    s = '0; s.ld_vld = 1; s.ld_hit = 1; s.ld_fwd = 32'hBEEF; s.ld_tag = 6'd3; step(s);
    s = '0; s.mem_resp = 1; step(s);
    drain();

    // SDQ full: store wins over a competing port load.
    s = '0; s.full = 1; s.st_vld = 1; s.st_addr = 32'h240; s.st_data = 32'h66;
    s.ld_vld = 1; s.ld_addr = 32'h140; s.ld_tag = 6'd11; step(s);
    chk("full_store_first", 64'(st_req_rdy), 64'(1));
    chk("full_load_waits", 64'(ld_req_rdy), 64'(0));
    drain();

    // Backpressure: request held for 4 cycles, no new grants.
    s = '0; s.ld_vld = 1; s.ld_addr = 32'h180; s.ld_tag = 6'd12; step(s);
    for (int i = 0; i < 4; i++) begin
      s = '0; s.ld_vld = 1; s.ld_addr = 32'h900 + 32'(i); s.ld_tag = 6'(20 + i);
      s.st_vld = 1; s.st_addr = 32'h280; s.st_data = 32'h99; step(s);
    end
    s = '0; s.mem_rdy = 1; step(s);
    s = '0; s.mem_resp = 1; s.mem_data = 32'h1234; step(s);
    drain();

    // Starvation: continuous port loads, store held until granted.
    st_done = 0; gnt_i = -1; gnts = 0;
    for (int i = 0; i < 30; i++) begin
      s = '0; s.ld_vld = 1; s.ld_addr = 32'h1000 + 32'(i); s.ld_tag = 6'(i);
      s.st_vld = !st_done; s.st_addr = 32'h300; s.st_data = 32'h77;
      s.mem_rdy = 1; s.mem_resp = (ph == 2); s.mem_data = $urandom;
      step(s);
      if (st_req_rdy) begin
        gnts++;
        st_done = 1;
        if (gnt_i < 0) gnt_i = i;
      end
    end
    chk("starve_grant_cycle", 64'(gnt_i), 64'(9));
    chk("starve_grant_pulses", 64'(gnts), 64'(1));
    drain();

    // Flush while load tag 7 waits: response consumed silently, port frees up.
    s = '0; s.ld_vld = 1; s.ld_addr = 32'h700; s.ld_tag = 6'd7; step(s);
    s = '0; s.mem_rdy = 1; step(s);
    s = '0; s.flush = 1; step(s);
    s = '0; s.mem_resp = 1; s.mem_data = 32'hBAD; step(s);
    s = '0; s.st_vld = 1; s.st_addr = 32'h380; s.st_data = 32'h88; step(s);
    chk("flush_back_to_idle", 64'(st_req_rdy), 64'(1));
    drain();

    // Reset while a request is offered.
    s = '0; s.ld_vld = 1; s.ld_addr = 32'h400; s.ld_tag = 6'd9; step(s);
    s = '0; s.rst = 1; step(s);
    s = '0; step(s);
    check_zero();
    drain();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      s = rnd_stim();
      step(s);
      if (last_st_g) st_have = 0;
    end
    drain();
    chk("mem_q_drained", 64'(mem_q.size()), 64'(0));
    chk("resp_q_drained", 64'(resp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
